calendar_param: RTL and testbench

CALENDAR_PARAM -- requirements
Module: calendar_param

---
 rtl/calendar_param.sv | 201 ++++++++++++++++++++
 tb/tb_calendar_param.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calendar_param.sv
// rtl/calendar_param.sv - calendar date counter with validated external load
// Define CAL_WEEKDAY_EN to build the weekday register, its load path and its range check.
module calendar_param #(
    parameter int YEAR_W      = 7,
    parameter int YEAR_BASE   = 2000,
    parameter int RESET_DAY   = 3,
    parameter int RESET_MONTH = 3,
    parameter int RESET_YEAR  = 24,
    parameter int RESET_WDAY  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              day_tick,
    input  logic              set,
    input  logic              inc_day,
    input  logic              inc_month,
    input  logic              inc_year,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [4:0]        load_day,
    input  logic [3:0]        load_month,
    input  logic [YEAR_W-1:0] load_year,
    input  logic [2:0]        load_wday,
    output logic [4:0]        day,
    output logic [3:0]        month,
    output logic [YEAR_W-1:0] year,
    output logic [2:0]        weekday,
    output logic              load_ok,
    output logic              load_err,
    output logic              year_wrap
);
    typedef enum logic {IDLE = 1'b0, CHECK = 1'b1} state_t;

    function automatic logic leap_of(input logic [YEAR_W-1:0] y);
        int f;
        f = YEAR_BASE + int'(y);
        return ((f % 4) == 0) && (((f % 100) != 0) || ((f % 400) == 0));
    endfunction

    function automatic logic [4:0] mlen(input logic [3:0] m, input logic lp);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: mlen = 5'd30;
            4'd2:                    mlen = lp ? 5'd29 : 5'd28;
            default:                 mlen = 5'd31;
        endcase
    endfunction

    state_t            state, next_state;
    logic              tick_q, inc_day_q, inc_month_q, inc_year_q;
    logic              tick_edge, manual, advance, pending, pending_n;
    logic [2:0]        key_edges;
    logic [4:0]        hold_day, day_q, day_n;
    logic [3:0]        hold_month, month_q, month_n, month_inc;
    logic [YEAR_W-1:0] hold_year, year_q, year_n, year_inc;
    logic              hold_valid, commit, reject, year_wrap_n, cur_leap;
    logic [4:0]        cur_len, len_next_month, len_next_year;

`ifdef CAL_WEEKDAY_EN
    logic [2:0] hold_wday, wday_q, wday_n;
`endif

    assign tick_edge      = day_tick & ~tick_q;
    assign key_edges      = {inc_day & ~inc_day_q, inc_month & ~inc_month_q, inc_year & ~inc_year_q};
    assign manual         = set && $onehot(key_edges);
    // A tick edge seen during CHECK is replayed on the following cycle
    assign pending_n      = (state == CHECK) && tick_edge && !set;
    assign advance        = pending || (tick_edge && !set && (state == IDLE));
    assign month_inc      = (month_q == 4'd12) ? 4'd1 : month_q + 4'd1;
    assign year_inc       = year_q + YEAR_W'(1);
    assign cur_leap       = leap_of(year_q);
    assign cur_len        = mlen(month_q, cur_leap);
    assign len_next_month = mlen(month_inc, cur_leap);
    assign len_next_year  = mlen(month_q, leap_of(year_inc));

    always_comb begin
        hold_valid = (hold_month >= 4'd1) && (hold_month <= 4'd12) && (hold_day >= 5'd1)
                  && (hold_day <= mlen(hold_month, leap_of(hold_year)));
`ifdef CAL_WEEKDAY_EN
        hold_valid = hold_valid && (hold_wday <= 3'd6);
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (load_valid) next_state = CHECK;
            CHECK: next_state = IDLE;
        endcase
    end

    always_comb begin
        load_ready = (state == IDLE);
        commit     = (state == CHECK) && hold_valid;
        reject     = (state == CHECK) && !hold_valid;
    end

    always_comb begin
        day_n       = day_q;
        month_n     = month_q;
        year_n      = year_q;
        year_wrap_n = 1'b0;
        if (commit) begin
            day_n   = hold_day;
            month_n = hold_month;
            year_n  = hold_year;
        end else if (manual) begin
            if (key_edges[2]) begin
                day_n = (day_q >= cur_len) ? 5'd1 : day_q + 5'd1;
            end else if (key_edges[1]) begin
                month_n = month_inc;
                day_n   = (day_q > len_next_month) ? len_next_month : day_q;
            end else begin
                year_n      = year_inc;
                year_wrap_n = &year_q;
                day_n       = (day_q > len_next_year) ? len_next_year : day_q;
            end
        end else if (advance) begin
            if (day_q < cur_len) begin
                day_n = day_q + 5'd1;
            end else begin
                day_n = 5'd1;
                if (month_q == 4'd12) begin
                    month_n     = 4'd1;
                    year_n      = year_inc;
                    year_wrap_n = &year_q;
                end else begin
                    month_n = month_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_q      <= 1'b0;
            inc_day_q   <= 1'b0;
            inc_month_q <= 1'b0;
            inc_year_q  <= 1'b0;
            pending     <= 1'b0;
            hold_day    <= '0;
            hold_month  <= '0;
            hold_year   <= '0;
            day_q       <= 5'(RESET_DAY);
            month_q     <= 4'(RESET_MONTH);
            year_q      <= YEAR_W'(RESET_YEAR);
            load_ok     <= 1'b0;
            load_err    <= 1'b0;
            year_wrap   <= 1'b0;
        end else begin
            tick_q      <= day_tick;
            inc_day_q   <= inc_day;
            inc_month_q <= inc_month;
            inc_year_q  <= inc_year;
            pending     <= pending_n;
            if (load_valid && load_ready) begin
                hold_day   <= load_day;
                hold_month <= load_month;
                hold_year  <= load_year;
            end
            day_q     <= day_n;
            month_q   <= month_n;
            year_q    <= year_n;
            load_ok   <= commit;
            load_err  <= reject;
            year_wrap <= year_wrap_n;
        end
    end

    assign day   = day_q;
    assign month = month_q;
    assign year  = year_q;

`ifdef CAL_WEEKDAY_EN
    always_comb begin
        wday_n = wday_q;
        if (commit)                wday_n = hold_wday;
        else if (!manual && advance) wday_n = (wday_q >= 3'd6) ? 3'd0 : wday_q + 3'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wday_q    <= 3'(RESET_WDAY);
            hold_wday <= '0;
        end else begin
            wday_q <= wday_n;
            if (load_valid && load_ready) hold_wday <= load_wday;
        end
    end

    assign weekday = wday_q;
`else
    logic unused_wday;
    assign unused_wday = ^load_wday;
    assign weekday     = 3'd0;
`endif
endmodule

// File: tb/tb_calendar_param.sv
// tb/tb_calendar_param.sv - randomized self-checking bench for calendar_param against a date model
module tb_calendar_param;
    localparam int YW = 7;
`ifdef CAL_WEEKDAY_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    typedef struct packed {
        int op; int a; int b; int c; int d;
        int ed; int em; int ey; int eok; int eerr; int ewrap;
    } row_t;

    logic          clk, reset, day_tick, set, inc_day, inc_month, inc_year, load_valid, load_ready;
    logic [4:0]    load_day, day;
    logic [3:0]    load_month, month;
    logic [YW-1:0] load_year, year;
    logic [2:0]    load_wday, weekday;
    logic          load_ok, load_err, year_wrap;
    logic [18:0]   dut_vec;
    int            checks, failures;
    int            md, mm, my, mw;
    int            days_tab[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

    assign dut_vec = {day, month, year, weekday};

    calendar_param dut (
        .clk(clk), .reset(reset), .day_tick(day_tick), .set(set),
        .inc_day(inc_day), .inc_month(inc_month), .inc_year(inc_year),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_day(load_day), .load_month(load_month), .load_year(load_year), .load_wday(load_wday),
        .day(day), .month(month), .year(year), .weekday(weekday),
        .load_ok(load_ok), .load_err(load_err), .year_wrap(year_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic int leap(input int yo);
        int f;
        f = 2000 + yo;
        return ((f % 4 == 0) && ((f % 100 != 0) || (f % 400 == 0))) ? 1 : 0;
    endfunction

    function automatic int mdays(input int m, input int yo);
        return days_tab[m - 1] + ((m == 2) ? leap(yo) : 0);
    endfunction

    function automatic logic [18:0] model_vec();
        return {5'(md), 4'(mm), 7'(my), 3'(mw)};
    endfunction

    function automatic void model_reset();
        md = 3; mm = 3; my = 24; mw = WD ? 6 : 0;
    endfunction

    function automatic bit model_tick();
        bit wrap;
        wrap = 1'b0;
        mw = WD ? (mw + 1) % 7 : 0;
        if (md < mdays(mm, my)) md++;
        else begin
            md = 1;
            if (mm == 12) begin
                mm = 1; my = (my + 1) % 128; wrap = (my == 0);
            end else mm++;
        end
        return wrap;
    endfunction

    function automatic bit model_keys(input int kd, input int km, input int ky);
        bit wrap;
        int len;
        wrap = 1'b0;
        if (kd + km + ky != 1) return 1'b0;
        if (kd != 0) md = (md % mdays(mm, my)) + 1;
        else begin
            if (km != 0) mm = (mm % 12) + 1;
            else begin
                my = (my + 1) % 128; wrap = (my == 0);
            end
            len = mdays(mm, my);
            if (md > len) md = len;
        end
        return wrap;
    endfunction

    function automatic bit model_load(input int d, input int m, input int y, input int w);
        bit valid;
        valid = (m >= 1) && (m <= 12) && (d >= 1) && (d <= mdays(m, y)) && (!WD || w <= 6);
        if (valid) begin
            md = d; mm = m; my = y; mw = WD ? w : 0;
        end
        return valid;
    endfunction

    function automatic row_t mk(input int op, input int a, input int b, input int c, input int d,
                                input int ed, input int em, input int ey,
                                input int eok, input int eerr, input int ewrap);
        return '{op, a, b, c, d, ed, em, ey, eok, eerr, ewrap};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_tick(output logic wr);
        day_tick = 1'b1; step(); wr = year_wrap;
        day_tick = 1'b0; step();
    endtask

    task automatic drive_set_tick(output logic wr);
        set = 1'b1; day_tick = 1'b1; step(); wr = year_wrap;
        day_tick = 1'b0; step(); set = 1'b0;
    endtask

    task automatic drive_keys(input bit kd, input bit km, input bit ky, output logic wr);
        set = 1'b1; inc_day = kd; inc_month = km; inc_year = ky; step(); wr = year_wrap;
        inc_day = 1'b0; inc_month = 1'b0; inc_year = 1'b0; step(); set = 1'b0;
    endtask

    task automatic drive_load(input int d, input int m, input int y, input int w,
                              output logic rb, output logic rc, output logic [18:0] mid,
                              output logic ok, output logic err);
        int n;
        n = 0;
        while (load_ready !== 1'b1 && n < 8) begin step(); n++; end
        rb = load_ready;
        load_valid = 1'b1; load_day = 5'(d); load_month = 4'(m); load_year = 7'(y); load_wday = 3'(w);
        step();
        rc = load_ready; mid = dut_vec; load_valid = 1'b0;
        step();
        ok = load_ok; err = load_err;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [18:0] expv;
        logic wr;
        step();
        expv = {5'd3, 4'd3, 7'd24, (WD ? 3'd6 : 3'd0)};
        checks++;
        if (dut_vec !== expv) begin failures++; $display("FAIL reset_date: got %h exp %h", dut_vec, expv); end
        checks++;
        if ({load_ok, load_err, year_wrap, load_ready} !== 4'b0001) begin
            failures++; $display("FAIL reset_status: got %b exp 0001", {load_ok, load_err, year_wrap, load_ready});
        end
        step();
        reset = 1'b1;
        model_reset();
        drive_tick(wr);
        void'(model_tick());
        expv = {5'd4, 4'd3, 7'd24, 3'd0};
        checks++;
        if (dut_vec !== expv || wr !== 1'b0) begin
            failures++; $display("FAIL first_tick: got %h wrap %b exp %h wrap 0", dut_vec, wr, expv);
        end
    endtask

    task automatic test_directed();
        row_t        rows[$];
        logic [18:0] pre, mid;
        logic        rb, rc, ok, err, wr;
        rows.push_back(mk(0, 29,  2,  24, 1,  29,  2,  24, 1, 0, 0));
        rows.push_back(mk(1,  0,  0,   0, 0,   1,  3,  24, 0, 0, 0));
        rows.push_back(mk(0, 29,  2,  23, 1,   1,  3,  24, 0, 1, 0));
        rows.push_back(mk(0, 28,  2, 100, 2,  28,  2, 100, 1, 0, 0));
        rows.push_back(mk(1,  0,  0,   0, 0,   1,  3, 100, 0, 0, 0));
        rows.push_back(mk(0, 28,  2,   0, 3,  28,  2,   0, 1, 0, 0));
        rows.push_back(mk(1,  0,  0,   0, 0,  29,  2,   0, 0, 0, 0));
        rows.push_back(mk(0, 31, 12, 127, 4,  31, 12, 127, 1, 0, 0));
        rows.push_back(mk(1,  0,  0,   0, 0,   1,  1,   0, 0, 0, 1));
        rows.push_back(mk(0, 31,  1,  24, 5,  31,  1,  24, 1, 0, 0));
        rows.push_back(mk(2,  0,  1,   0, 0,  29,  2,  24, 0, 0, 0));
        rows.push_back(mk(2,  0,  0,   1, 0,  28,  2,  25, 0, 0, 0));
        rows.push_back(mk(3,  0,  0,   0, 0,  28,  2,  25, 0, 0, 0));
        rows.push_back(mk(2,  1,  0,   1, 0,  28,  2,  25, 0, 0, 0));
        rows.push_back(mk(2,  1,  0,   0, 0,   1,  2,  25, 0, 0, 0));
        rows.push_back(mk(0, 31,  4,  50, 0,   1,  2,  25, 0, 1, 0));
        rows.push_back(mk(0,  0,  5,   5, 0,   1,  2,  25, 0, 1, 0));
        rows.push_back(mk(0,  1, 13,   5, 0,   1,  2,  25, 0, 1, 0));
        rows.push_back(mk(0, 10,  6, 127, 6,  10,  6, 127, 1, 0, 0));
        rows.push_back(mk(2,  0,  0,   1, 0,  10,  6,   0, 0, 0, 1));
        rows.push_back(mk(0, 31, 12,  10, 0,  31, 12,  10, 1, 0, 0));
        rows.push_back(mk(2,  0,  1,   0, 0,  31,  1,  10, 0, 0, 0));
        rows.push_back(mk(2,  1,  0,   0, 0,   1,  1,  10, 0, 0, 0));
        rows.push_back(mk(0, 30,  9,  10, 1,  30,  9,  10, 1, 0, 0));
        rows.push_back(mk(1,  0,  0,   0, 0,   1, 10,  10, 0, 0, 0));
        foreach (rows[i]) begin
            row_t r;
            r = rows[i];
            pre = dut_vec; mid = pre; rb = 1'b1; rc = 1'b0; ok = 1'b0; err = 1'b0; wr = 1'b0;
            case (r.op)
                0: begin drive_load(r.a, r.b, r.c, r.d, rb, rc, mid, ok, err); void'(model_load(r.a, r.b, r.c, r.d)); end
                1: begin drive_tick(wr); void'(model_tick()); end
                2: begin drive_keys(r.a != 0, r.b != 0, r.c != 0, wr); void'(model_keys(r.a, r.b, r.c)); end
                default: drive_set_tick(wr);
            endcase
            checks++;
            if (dut_vec[18:3] !== {5'(r.ed), 4'(r.em), 7'(r.ey)}) begin
                failures++; $display("FAIL dir_date[%0d]: got %0d/%0d/%0d exp %0d/%0d/%0d", i, day, month, year, r.ed, r.em, r.ey);
            end
            checks++;
            if (weekday !== 3'(mw)) begin failures++; $display("FAIL dir_wday[%0d]: got %0d exp %0d", i, weekday, mw); end
            if (r.op == 0) begin
                checks++;
                if ({ok, err} !== {r.eok[0], r.eerr[0]}) begin
                    failures++; $display("FAIL dir_status[%0d]: got ok=%b err=%b exp ok=%0d err=%0d", i, ok, err, r.eok, r.eerr);
                end
                checks++;
                if ({rb, rc} !== 2'b10) begin failures++; $display("FAIL dir_ready[%0d]: got %b exp 10", i, {rb, rc}); end
                checks++;
                if (mid !== pre) begin failures++; $display("FAIL dir_early_commit[%0d]: got %h exp %h", i, mid, pre); end
            end else begin
                checks++;
                if (wr !== r.ewrap[0]) begin failures++; $display("FAIL dir_wrap[%0d]: got %b exp %0d", i, wr, r.ewrap); end
            end
        end
    endtask

    task automatic test_pending_tick();
        load_valid = 1'b1; load_day = 5'd10; load_month = 4'd5; load_year = 7'd30; load_wday = 3'd2;
        step();
        load_valid = 1'b0; day_tick = 1'b1;
        step();
        void'(model_load(10, 5, 30, 2));
        checks++;
        if (dut_vec !== model_vec() || load_ok !== 1'b1) begin
            failures++; $display("FAIL pend_commit: got %h ok %b exp %h ok 1", dut_vec, load_ok, model_vec());
        end
        day_tick = 1'b0;
        step();
        void'(model_tick());
        checks++;
        if (dut_vec !== model_vec() || dut_vec[18:3] !== {5'd11, 4'd5, 7'd30}) begin
            failures++; $display("FAIL pend_apply: got %h exp %h", dut_vec, model_vec());
        end
        load_valid = 1'b1; load_day = 5'd31; load_month = 4'd4; load_year = 7'd30; load_wday = 3'd0;
        step();
        load_valid = 1'b0; day_tick = 1'b1;
        step();
        checks++;
        if (dut_vec !== model_vec() || load_err !== 1'b1) begin
            failures++; $display("FAIL pend_reject: got %h err %b exp %h err 1", dut_vec, load_err, model_vec());
        end
        day_tick = 1'b0;
        step();
        void'(model_tick());
        checks++;
        if (dut_vec !== model_vec()) begin failures++; $display("FAIL pend_after_err: got %h exp %h", dut_vec, model_vec()); end
    endtask

    task automatic test_back_to_back();
        load_valid = 1'b1; load_day = 5'd20; load_month = 4'd7; load_year = 7'd60; load_wday = 3'd1;
        step();
        checks++;
        if (load_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_check: got %b exp 0", load_ready); end
        load_day = 5'd5; load_month = 4'd8; load_year = 7'd61; load_wday = 3'd3;
        step();
        void'(model_load(20, 7, 60, 1));
        checks++;
        if (dut_vec !== model_vec() || load_ok !== 1'b1) begin
            failures++; $display("FAIL b2b_first: got %h ok %b exp %h ok 1", dut_vec, load_ok, model_vec());
        end
        step();
        checks++;
        if (dut_vec !== model_vec() || {load_ok, load_err} !== 2'b00) begin
            failures++; $display("FAIL b2b_gap: got %h st %b exp %h st 00", dut_vec, {load_ok, load_err}, model_vec());
        end
        load_valid = 1'b0;
        step();
        void'(model_load(5, 8, 61, 3));
        checks++;
        if (dut_vec !== model_vec() || load_ok !== 1'b1) begin
            failures++; $display("FAIL b2b_second: got %h ok %b exp %h ok 1", dut_vec, load_ok, model_vec());
        end
    endtask

    task automatic test_reset_in_check();
        load_valid = 1'b1; load_day = 5'd15; load_month = 4'd6; load_year = 7'd40; load_wday = 3'd0;
        step();
        load_valid = 1'b0;
        reset = 1'b0;
        #2;
        model_reset();
        checks++;
        if (dut_vec !== model_vec()) begin failures++; $display("FAIL rst_async: got %h exp %h", dut_vec, model_vec()); end
        reset = 1'b1;
        step();
        checks++;
        if ({load_ok, load_err} !== 2'b00 || dut_vec !== model_vec()) begin
            failures++; $display("FAIL rst_abort: got %h st %b exp %h st 00", dut_vec, {load_ok, load_err}, model_vec());
        end
        checks++;
        if (load_ready !== 1'b1) begin failures++; $display("FAIL rst_idle: got %b exp 1", load_ready); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            int op, d, m, y, w, k;
            logic rb, rc, ok, err, wr;
            logic [18:0] pre, mid;
            bit ev, ewr;
            op = $urandom_range(0, 9);
            pre = dut_vec; wr = 1'b0; ewr = 1'b0;
            if (op < 3) begin
                m = $urandom_range(1, 12); y = $urandom_range(0, 127);
                d = $urandom_range(1, mdays(m, y)); w = $urandom_range(0, 6);
                case ($urandom_range(0, 3))
                    0: begin d = $urandom_range(0, 31); m = $urandom_range(0, 15); w = $urandom_range(0, 7); end
                    1: d = mdays(m, y);
                    2: begin m = 12; d = 31; y = $urandom_range(125, 127); end
                    default: ;
                endcase
                drive_load(d, m, y, w, rb, rc, mid, ok, err);
                ev = model_load(d, m, y, w);
                checks++;
                if ({ok, err, rb, rc} !== {ev, !ev, 1'b1, 1'b0}) begin
                    failures++; $display("FAIL rnd_load[%0d]: got ok/err/rdy %b exp %b for %0d/%0d/%0d w%0d", i, {ok, err, rb, rc}, {ev, !ev, 2'b10}, d, m, y, w);
                end
                checks++;
                if (mid !== pre) begin failures++; $display("FAIL rnd_early[%0d]: got %h exp %h", i, mid, pre); end
            end else begin
                if (op < 7) begin
                    drive_tick(wr); ewr = model_tick();
                end else if (op < 9) begin
                    k = $urandom_range(1, 7);
                    drive_keys(k[0], k[1], k[2], wr); ewr = model_keys(k & 1, (k >> 1) & 1, (k >> 2) & 1);
                end else begin
                    drive_set_tick(wr);
                end
                checks++;
                if (wr !== ewr) begin failures++; $display("FAIL rnd_wrap[%0d]: op %0d got %b exp %b", i, op, wr, ewr); end
            end
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++; $display("FAIL rnd_date[%0d]: op %0d got %h exp %h", i, op, dut_vec, model_vec());
            end
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b0; day_tick = 1'b0; set = 1'b0;
        inc_day = 1'b0; inc_month = 1'b0; inc_year = 1'b0; load_valid = 1'b0;
        load_day = '0; load_month = '0; load_year = '0; load_wday = '0;
        model_reset();
        test_reset();
        test_directed();
        test_pending_tick();
        test_back_to_back();
        test_reset_in_check();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
